// File: rtl/mult_sequencer.sv
// mult_sequencer: shares one combinational WIDTH x WIDTH multiplier array
// between two requesters. Round-robin arbitration picks a requester, and the
// sequencer holds its operands on the array for SETTLE_CYCLES clocks. It then
// captures the product and returns it over a valid/ready response channel.
//
// Ports
//   clk, rst_n                  clock (rising edge), async active-low reset
//   req0_valid/ready/a/b        requester 0 operand handshake
//   req1_valid/ready/a/b        requester 1 operand handshake
//   mul_a, mul_b                registered operands driven to the array
//   mul_p                       unregistered product from the array
//   rsp_valid/ready/id/p        product response handshake
//   busy                        operation in flight or response pending
module mult_sequencer #(
  parameter int unsigned WIDTH         = 16,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [WIDTH-1:0]     req0_a,
  input  logic [WIDTH-1:0]     req0_b,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [WIDTH-1:0]     req1_a,
  input  logic [WIDTH-1:0]     req1_b,
  output logic [WIDTH-1:0]     mul_a,
  output logic [WIDTH-1:0]     mul_b,
  input  logic [2*WIDTH-1:0]   mul_p,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_id,
  output logic [2*WIDTH-1:0]   rsp_p,
  output logic                 busy
);

  localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic             last_grant;
  logic [CNT_W-1:0] cnt;
  logic             grant_vld;
  logic             grant_id;
  logic             accept;
  logic             capture;
  logic             retire;

  // Round-robin pick: lone requester wins, on contention the one not served last
  always_comb begin
    grant_vld = req0_valid | req1_valid;
    grant_id  = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_id = ~last_grant;
    end else if (req1_valid) begin
      grant_id = 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (grant_vld)      state_nx = SETTLE;
      SETTLE:  if (cnt == CNT_ONE) state_nx = RESP;
      RESP:    if (rsp_ready)      state_nx = IDLE;
      default:                     state_nx = IDLE;
    endcase
  end

  // Control strobes and request handshakes; ready is gated by rst_n so a
  // requester never sees acceptance while the block is held in reset
  always_comb begin
    accept     = 1'b0;
    capture    = 1'b0;
    retire     = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state)
      IDLE: begin
        accept     = rst_n & grant_vld;
        req0_ready = rst_n & grant_vld & ~grant_id;
        req1_ready = rst_n & grant_vld & grant_id;
      end
      SETTLE:  capture = (cnt == CNT_ONE);
      RESP:    retire  = rsp_ready;
      default: ;
    endcase
  end

  // Operand launch, settle countdown and product capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_a      <= '0;
      mul_b      <= '0;
      rsp_id     <= 1'b0;
      rsp_p      <= '0;
      rsp_valid  <= 1'b0;
      last_grant <= 1'b1;
      cnt        <= '0;
    end else begin
      if (accept) begin
        mul_a      <= grant_id ? req1_a : req0_a;
        mul_b      <= grant_id ? req1_b : req0_b;
        rsp_id     <= grant_id;
        last_grant <= grant_id;
        cnt        <= CNT_LOAD;
      end
      if (state == SETTLE) begin
        cnt <= cnt - CNT_ONE;
      end
      if (capture) begin
        rsp_p     <= mul_p;
        rsp_valid <= 1'b1;
      end
      if (retire) begin
        rsp_valid <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_mult_sequencer.sv
// Directed bench for mult_sequencer. A behavioural array model drives a
// glitch value on mul_p until the operands have been stable for settle_t.
module tb_mult_sequencer;

  localparam logic [31:0] GLITCH = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic [15:0] mul_a, mul_b;
  logic [31:0] mul_p;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [31:0] rsp_p;
  logic        busy;

  int  checks = 0;
  int  errors = 0;
  int  lat;
  time chg_time = 0;
  time settle_t = 200;

  mult_sequencer #(.WIDTH(16), .SETTLE_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_p(rsp_p),
    .busy(busy)
  );

  always #50 clk = ~clk;

  always @(mul_a or mul_b) chg_time = $time;

  // Array model, updated off the clock grid so capture never races it
  initial begin
    mul_p = GLITCH;
    #3;
    forever begin
      if (($time - chg_time) >= settle_t) mul_p = 32'(mul_a) * 32'(mul_b);
      else                                mul_p = GLITCH;
      #10;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Count edges from the accept edge until rsp_valid is seen (bounded)
  task automatic wait_rsp(output int n);
    n = 0;
    while (rsp_valid !== 1'b1 && n < 20) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rsp_ready  = 1'b1;
    req0_valid = 1'b1; req0_a = 16'd2;     req0_b = 16'd7;
    req1_valid = 1'b1; req1_a = 16'hFFFF;  req1_b = 16'hFFFF;

    // T1: reset with both requesters valid
    #1 rst_n = 1'b0;
    #2;
    chk("t1_req0_ready", 64'(req0_ready), 64'd0);
    chk("t1_req1_ready", 64'(req1_ready), 64'd0);
    chk("t1_rsp_valid",  64'(rsp_valid),  64'd0);
    chk("t1_busy",       64'(busy),       64'd0);
    chk("t1_mul_a",      64'(mul_a),      64'd0);
    chk("t1_mul_b",      64'(mul_b),      64'd0);
    chk("t1_rsp_p",      64'(rsp_p),      64'd0);
    chk("t1_rsp_id",     64'(rsp_id),     64'd0);

    // T3: contention from reset, req0 first
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("t3_req0_ready", 64'(req0_ready), 64'd1);
    chk("t3_req1_ready", 64'(req1_ready), 64'd0);
    next_cycle();
    chk("t3_busy",       64'(busy),       64'd1);
    chk("t3_mul_a0",     64'(mul_a),      64'd2);
    chk("t3_mul_b0",     64'(mul_b),      64'd7);
    chk("t3_settle_rdy", 64'(req1_ready), 64'd0);
    req0_valid = 1'b0;
    wait_rsp(lat);
    chk("t3_lat0",       64'(lat),        64'd4);
    chk("t3_rsp_p0",     64'(rsp_p),      64'd14);
    chk("t3_rsp_id0",    64'(rsp_id),     64'd0);
    next_cycle();
    chk("t3_idle_busy",  64'(busy),       64'd0);
    chk("t3_idle_valid", 64'(rsp_valid),  64'd0);
    chk("t3_req1_ready", 64'(req1_ready), 64'd1);
    next_cycle();
    chk("t3_mul_a1",     64'(mul_a),      64'hFFFF);
    req1_valid = 1'b0;
    wait_rsp(lat);
    chk("t3_lat1",       64'(lat),        64'd4);
    chk("t3_rsp_p1",     64'(rsp_p),      64'hFFFE0001);
    chk("t3_rsp_id1",    64'(rsp_id),     64'd1);
    next_cycle();
    chk("t3_done_busy",  64'(busy),       64'd0);

    // T2: single operation
    req0_valid = 1'b1; req0_a = 16'd3; req0_b = 16'd5;
    #1;
    chk("t2_req0_ready", 64'(req0_ready), 64'd1);
    next_cycle();
    req0_valid = 1'b0;
    wait_rsp(lat);
    chk("t2_lat",        64'(lat),        64'd4);
    chk("t2_rsp_p",      64'(rsp_p),      64'd15);
    chk("t2_rsp_id",     64'(rsp_id),     64'd0);
    next_cycle();

    // T4: response backpressure with a pending request
    rsp_ready  = 1'b0;
    req0_valid = 1'b1; req0_a = 16'd4; req0_b = 16'd6;
    next_cycle();
    req0_valid = 1'b0;
    wait_rsp(lat);
    chk("t4_lat",        64'(lat),        64'd4);
    req1_valid = 1'b1; req1_a = 16'd1; req1_b = 16'd1;
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      chk("t4_rsp_valid", 64'(rsp_valid),  64'd1);
      chk("t4_rsp_p",     64'(rsp_p),      64'd24);
      chk("t4_rsp_id",    64'(rsp_id),     64'd0);
      chk("t4_req0_rdy",  64'(req0_ready), 64'd0);
      chk("t4_req1_rdy",  64'(req1_ready), 64'd0);
      chk("t4_busy",      64'(busy),       64'd1);
    end
    rsp_ready = 1'b1;
    next_cycle();
    chk("t4_rel_valid",  64'(rsp_valid),  64'd0);
    chk("t4_rel_busy",   64'(busy),       64'd0);
    chk("t4_rel_rdy1",   64'(req1_ready), 64'd1);
    chk("t4_hold_mul_a", 64'(mul_a),      64'd4);
    req1_valid = 1'b0;
    next_cycle();
    chk("t4_drop_busy",  64'(busy),       64'd0);

    // T5: array glitches for 35ns equivalent; only the settled product is captured
    settle_t = 350;
    req0_valid = 1'b1; req0_a = 16'h1234; req0_b = 16'h5678;
    next_cycle();
    req0_valid = 1'b0;
    wait_rsp(lat);
    chk("t5_lat",        64'(lat),        64'd4);
    chk("t5_rsp_p",      64'(rsp_p),      64'h06260060);
    chk("t5_rsp_id",     64'(rsp_id),     64'd0);
    next_cycle();

    // T6: reset while cnt==2 discards the operation
    settle_t = 200;
    req0_valid = 1'b1; req0_a = 16'd7; req0_b = 16'd7;
    next_cycle();
    req0_valid = 1'b0;
    next_cycle();
    next_cycle();
    rst_n = 1'b0;
    #1;
    chk("t6_rst_busy",   64'(busy),       64'd0);
    chk("t6_rst_valid",  64'(rsp_valid),  64'd0);
    chk("t6_rst_mul_a",  64'(mul_a),      64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      chk("t6_no_rsp",   64'(rsp_valid),  64'd0);
    end
    req1_valid = 1'b1; req1_a = 16'd9; req1_b = 16'd9;
    #1;
    chk("t6_req1_ready", 64'(req1_ready), 64'd1);
    next_cycle();
    req1_valid = 1'b0;
    wait_rsp(lat);
    chk("t6_lat",        64'(lat),        64'd4);
    chk("t6_rsp_p",      64'(rsp_p),      64'd81);
    chk("t6_rsp_id",     64'(rsp_id),     64'd1);
    next_cycle();
    chk("t6_done_busy",  64'(busy),       64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
